// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
//
// Contents:
//   frame_state_e   frame FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_EXT         extended-key prefix byte (E0)
//   PS2_BRK         key-release prefix byte (F0)
//   PS2_FRAME_BITS  bits per PS/2 frame (start + 8 data + parity + stop)
//   PS2_DATA_BITS   data bits per frame
//   parity_ok()     true when data plus parity bit has odd weight
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;
  localparam int         PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame receiver: clock edge detect, framing, checks, timeout
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   kbclk       debounced PS/2 clock level
//   kbdata      PS/2 data line, synchronised to clk
//   rx_byte     received data byte (valid while byte_ok is high)
//   byte_ok     one-cycle strobe in the stop-bit fall cycle of a good frame
//   err_parity  one-cycle pulse after a frame with bad parity
//   err_frame   one-cycle pulse after a bad start/stop bit or a mid-frame timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbclk,
  input  logic       kbdata,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int          TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_BIT = 4'(PS2_DATA_BITS - 1);

  frame_state_e  state, state_nxt;
  logic          kbclk_q;
  logic          fall;
  logic [7:0]    shreg;
  logic [3:0]    bitcnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          perr_nxt, ferr_nxt;

  assign fall    = kbclk_q & ~kbclk;
  // A fall in the same cycle as the counter expiring wins over the timeout.
  assign timeout = (state != IDLE) && !fall && (tcnt == T_LAST);
  assign rx_byte = shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kbclk_q    <= 1'b1;
      shreg      <= '0;
      bitcnt     <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      state      <= state_nxt;
      kbclk_q    <= kbclk;
      err_parity <= perr_nxt;
      err_frame  <= ferr_nxt;

      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shreg  <= {kbdata, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          PARITY: par_bit <= kbdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    byte_ok   = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (fall) begin
          if (!kbdata) state_nxt = DATA;
          else         ferr_nxt  = 1'b1;
        end
      end
      DATA: begin
        if (fall && bitcnt == LAST_BIT) state_nxt = PARITY;
      end
      PARITY: begin
        if (fall) state_nxt = STOP;
      end
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          if (!kbdata)                        ferr_nxt = 1'b1;
          else if (!parity_ok(shreg, par_bit)) perr_nxt = 1'b1;
          else                                byte_ok  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (timeout) begin
      state_nxt = IDLE;
      ferr_nxt  = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_ctrl.sv
// rtl/ps2_ctrl.sv - PS/2 keyboard controller: prefix decode and one-entry event buffer
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   kbclk       debounced PS/2 clock level
//   kbdata      PS/2 data line, synchronised to clk
//   code_ready  consumer accepts the buffered event when high with code_valid
//   code_valid  event present in the buffer
//   code        scan code byte with E0/F0 prefixes stripped
//   code_break  event is a key release (F0 seen)
//   code_ext    event is an extended key (E0 seen)
//   err_parity  one-cycle pulse: parity failure, frame dropped
//   err_frame   one-cycle pulse: bad start/stop bit or timeout
//   overflow    one-cycle pulse: event dropped because the buffer was full
module ps2_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbclk,
  input  logic       kbdata,
  input  logic       code_ready,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       code_break,
  output logic       code_ext,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  logic [7:0] rx_byte;
  logic       byte_ok;
  logic       ext_pend, brk_pend;
  logic       is_ext, is_brk, emit;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .kbclk     (kbclk),
    .kbdata    (kbdata),
    .rx_byte   (rx_byte),
    .byte_ok   (byte_ok),
    .err_parity(err_parity),
    .err_frame (err_frame)
  );

  assign is_ext = byte_ok && (rx_byte == PS2_EXT);
  assign is_brk = byte_ok && (rx_byte == PS2_BRK);
  assign emit   = byte_ok && !is_ext && !is_brk;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      code_valid <= 1'b0;
      code       <= '0;
      code_break <= 1'b0;
      code_ext   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;

      // Prefix flags survive error frames; only a completed key event clears them.
      if (is_ext) ext_pend <= 1'b1;
      if (is_brk) brk_pend <= 1'b1;

      if (emit) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
        // Loading is allowed when the slot is empty or being drained this cycle.
        if (!code_valid || code_ready) begin
          code_valid <= 1'b1;
          code       <= rx_byte;
          code_break <= brk_pend;
          code_ext   <= ext_pend;
        end else begin
          overflow <= 1'b1;
        end
      end else if (code_valid && code_ready) begin
        code_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_ctrl.sv
// tb/tb_ps2_ctrl.sv - directed self-checking bench for ps2_ctrl
module tb_ps2_ctrl;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbclk = 1'b1;
  logic       kbdata = 1'b1;
  logic       code_ready = 1'b1;
  logic       code_valid;
  logic [7:0] code;
  logic       code_break;
  logic       code_ext;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  int         n_evt = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
  logic [7:0] last_code = 8'h00;

  logic       s_valid;
  logic [7:0] s_code;
  logic       s_brk, s_ext;

  ps2_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .kbclk     (kbclk),
    .kbdata    (kbdata),
    .code_ready(code_ready),
    .code_valid(code_valid),
    .code      (code),
    .code_break(code_break),
    .code_ext  (code_ext),
    .err_parity(err_parity),
    .err_frame (err_frame),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid && code_ready) begin
        n_evt++;
        last_code = code;
      end
      if (err_parity) n_perr++;
      if (err_frame)  n_ferr++;
      if (overflow)   n_ovf++;
    end
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1 kbdata = b;
    repeat (2) @(posedge clk);
    #1 kbclk = 1'b0;
    repeat (3) @(posedge clk);
    #1 kbclk = 1'b1;
  endtask

  // Full frame; snapshot of the buffer is taken one cycle after the stop-bit fall.
  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ flip_par);
    @(posedge clk); #1 kbdata = stop_val;
    repeat (2) @(posedge clk);
    #1 kbclk = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_valid = code_valid;
    s_code  = code;
    s_brk   = code_break;
    s_ext   = code_ext;
    repeat (2) @(posedge clk);
    #1 kbclk = 1'b1; kbdata = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", code_valid); end
    n_cmp++; if (code !== 8'h00) begin n_bad++; $display("FAIL reset_code got %h want 00", code); end
    n_cmp++; if ({code_break, code_ext} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {code_break, code_ext}); end
    n_cmp++; if ({err_parity, err_frame, overflow} !== 3'b000) begin n_bad++; $display("FAIL reset_errs got %b want 000", {err_parity, err_frame, overflow}); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_make;
    int e0;
    e0 = n_evt;
    send_frame(8'h1C, 1'b0, 1'b1);
    n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL make_latency got %b want 1", s_valid); end
    n_cmp++; if (s_code !== 8'h1C) begin n_bad++; $display("FAIL make_code got %h want 1c", s_code); end
    n_cmp++; if ({s_brk, s_ext} !== 2'b00) begin n_bad++; $display("FAIL make_flags got %b want 00", {s_brk, s_ext}); end
    n_cmp++; if (n_evt - e0 !== 1) begin n_bad++; $display("FAIL make_count got %0d want 1", n_evt - e0); end
    n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL make_drain got %b want 0", code_valid); end
  endtask

  task automatic test_break;
    int e0;
    e0 = n_evt;
    send_frame(8'hF0, 1'b0, 1'b1);
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL brk_prefix_valid got %b want 0", s_valid); end
    send_frame(8'h1C, 1'b0, 1'b1);
    n_cmp++; if ({s_valid, s_code} !== {1'b1, 8'h1C}) begin n_bad++; $display("FAIL brk_code got %b/%h want 1/1c", s_valid, s_code); end
    n_cmp++; if ({s_brk, s_ext} !== 2'b10) begin n_bad++; $display("FAIL brk_flags got %b want 10", {s_brk, s_ext}); end
    n_cmp++; if (n_evt - e0 !== 1) begin n_bad++; $display("FAIL brk_count got %0d want 1", n_evt - e0); end
  endtask

  task automatic test_ext_break;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    n_cmp++; if ({s_valid, s_code} !== {1'b1, 8'h75}) begin n_bad++; $display("FAIL extbrk_code got %b/%h want 1/75", s_valid, s_code); end
    n_cmp++; if ({s_brk, s_ext} !== 2'b11) begin n_bad++; $display("FAIL extbrk_flags got %b want 11", {s_brk, s_ext}); end
    send_frame(8'h75, 1'b0, 1'b1);
    n_cmp++; if ({s_valid, s_code, s_brk, s_ext} !== {1'b1, 8'h75, 2'b00}) begin n_bad++; $display("FAIL ext_cleared got %b/%h/%b want 1/75/00", s_valid, s_code, {s_brk, s_ext}); end
  endtask

  task automatic test_errors;
    int e0, p0, f0;
    e0 = n_evt; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h1C, 1'b1, 1'b1);
    n_cmp++; if (n_perr - p0 !== 1) begin n_bad++; $display("FAIL parity_pulse got %0d want 1", n_perr - p0); end
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL parity_no_event got %b want 0", s_valid); end
    send_frame(8'h1C, 1'b0, 1'b0);
    n_cmp++; if (n_ferr - f0 !== 1) begin n_bad++; $display("FAIL stop_pulse got %0d want 1", n_ferr - f0); end
    n_cmp++; if (n_evt - e0 !== 0) begin n_bad++; $display("FAIL err_no_event got %0d want 0", n_evt - e0); end
  endtask

  task automatic test_timeout;
    int f0;
    f0 = n_ferr;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TO + 16) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (n_ferr - f0 !== 1) begin n_bad++; $display("FAIL timeout_pulse got %0d want 1", n_ferr - f0); end
    send_frame(8'h1C, 1'b0, 1'b1);
    n_cmp++; if ({s_valid, s_code, s_brk, s_ext} !== {1'b1, 8'h1C, 2'b01}) begin n_bad++; $display("FAIL timeout_recover got %b/%h/%b want 1/1c/01", s_valid, s_code, {s_brk, s_ext}); end
  endtask

  task automatic test_overflow;
    int e0, o0;
    e0 = n_evt; o0 = n_ovf;
    @(posedge clk); #1 code_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    n_cmp++; if ({s_valid, s_code} !== {1'b1, 8'h1C}) begin n_bad++; $display("FAIL ovf_first got %b/%h want 1/1c", s_valid, s_code); end
    send_frame(8'h32, 1'b0, 1'b1);
    n_cmp++; if (n_ovf - o0 !== 1) begin n_bad++; $display("FAIL ovf_pulse got %0d want 1", n_ovf - o0); end
    n_cmp++; if ({code_valid, code} !== {1'b1, 8'h1C}) begin n_bad++; $display("FAIL ovf_hold got %b/%h want 1/1c", code_valid, code); end
    @(posedge clk); #1 code_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drain got %b want 0", code_valid); end
    n_cmp++; if ({n_evt - e0, last_code} !== {32'sd1, 8'h1C}) begin n_bad++; $display("FAIL ovf_accept got %0d/%h want 1/1c", n_evt - e0, last_code); end
  endtask

  task automatic test_reset_midframe;
    int p0, f0;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    p0 = n_perr; f0 = n_ferr;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (TO + 8) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({n_perr - p0, n_ferr - f0} !== 64'd0) begin n_bad++; $display("FAIL midrst_errs got %0d/%0d want 0/0", n_perr - p0, n_ferr - f0); end
    send_frame(8'h1C, 1'b0, 1'b1);
    n_cmp++; if ({s_valid, s_code, s_brk, s_ext} !== {1'b1, 8'h1C, 2'b00}) begin n_bad++; $display("FAIL midrst_recover got %b/%h/%b want 1/1c/00", s_valid, s_code, {s_brk, s_ext}); end
  endtask

  initial begin
    test_reset;
    test_make;
    test_break;
    test_ext_break;
    test_errors;
    test_timeout;
    test_overflow;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
